// File: rtl/mux16_rr_sched.sv
// Round-robin scheduler that shares one 16:1 result mux among 16 requesters and
// registers the selected data into a single-entry valid/ready output buffer.
module mux16_rr_sched #(
    parameter int DW   = 32,
    parameter int NREQ = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [3:0]      sel,
    input  logic [DW-1:0]   mux_out,
    output logic [DW-1:0]   out_data,
    output logic [3:0]      out_src,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [15:0]     busy_cnt
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t     state;
    logic [3:0] last_ptr;
    logic [3:0] sel_q;
    logic [3:0] winner;
    logic [3:0] idx;
    logic       found;
    logic       grant;
    logic       can_load;

    // Scan from the slot after the last winner; k=16 wraps back onto last_ptr itself,
    // so a lone requester can be granted back-to-back.
    always_comb begin
        can_load = !rst && ((state == EMPTY) || (out_valid && out_ready));
        found    = 1'b0;
        winner   = '0;
        idx      = '0;
        for (int k = 1; k <= 16; k++) begin
            idx = last_ptr + 4'(k);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
        grant = can_load && found;
        gnt   = '0;
        if (grant) begin
            gnt[winner] = 1'b1;
        end
        sel = grant ? winner : sel_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            last_ptr  <= 4'd15;
            sel_q     <= '0;
            busy_cnt  <= '0;
        end else begin
            if (grant) begin
                out_data  <= mux_out;
                out_src   <= winner;
                last_ptr  <= winner;
                sel_q     <= winner;
                out_valid <= 1'b1;
                state     <= FULL;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                state     <= EMPTY;
            end
            // Stall monitor saturates rather than wrapping.
            if ((|req) && !grant && (busy_cnt != 16'hFFFF)) begin
                busy_cnt <= busy_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_mux16_rr_sched.sv
// Self-checking bench for mux16_rr_sched: a reference arbiter model pushes expected
// transfers into a scoreboard queue that is popped as the output buffer drains.
module tb_mux16_rr_sched;

    localparam int DW = 32;

    typedef struct packed {
        logic [3:0]    src;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   req;
    logic [15:0]   gnt;
    logic [3:0]    sel;
    logic [DW-1:0] mux_out;
    logic [DW-1:0] out_data;
    logic [3:0]    out_src;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   busy_cnt;

    int assertCount = 0;
    int failCount   = 0;

    exp_t       expQ[$];
    logic [3:0] mLast;
    logic [3:0] mSel;
    logic       mValid;
    int         mBusy;

    mux16_rr_sched #(.DW(DW), .NREQ(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .sel       (sel),
        .mux_out   (mux_out),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy_cnt  (busy_cnt)
    );

    // External MUX16T1_32 stand-in: input Ii carries the value i.
    assign mux_out = DW'(sel);

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Hold reset for n cycles; grants must stay off even with requests pending.
    task automatic resetDut(input int n, input logic [15:0] r);
        rst       = 1'b1;
        req       = r;
        out_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            #1;
            checkOutput("gnt_in_reset", 32'(gnt), 32'd0);
            @(negedge clk);
        end
        rst    = 1'b0;
        mLast  = 4'd15;
        mSel   = 4'd0;
        mValid = 1'b0;
        mBusy  = 0;
        expQ.delete();
    endtask

    // One clock cycle: drive inputs, check against the model, then advance the model.
    task automatic applyStimulus(input logic [15:0] r, input logic rdy);
        logic       canLoad;
        logic       found;
        logic [3:0] win;
        logic [3:0] idx;
        logic [15:0] expGnt;
        exp_t       head;
        req       = r;
        out_ready = rdy;
        #1;
        canLoad = !mValid || rdy;
        found   = 1'b0;
        win     = 4'd0;
        for (int k = 1; k <= 16; k++) begin
            idx = 4'((int'(mLast) + k) % 16);
            if (!found && r[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        found  = found && canLoad;
        expGnt = found ? (16'd1 << win) : 16'd0;
        checkOutput("gnt", 32'(gnt), 32'(expGnt));
        checkOutput("sel", 32'(sel), 32'(found ? win : mSel));
        checkOutput("out_valid", 32'(out_valid), 32'(mValid));
        checkOutput("busy_cnt", 32'(busy_cnt), 32'(mBusy));
        if (mValid) begin
            if (expQ.size() == 0) begin
                checkOutput("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                head = expQ[0];
                checkOutput("out_src", 32'(out_src), 32'(head.src));
                checkOutput("out_data", out_data, head.data);
            end
        end
        if (mValid && rdy && expQ.size() != 0) begin
            void'(expQ.pop_front());
        end
        if (found) begin
            expQ.push_back('{src: win, data: DW'(win)});
            mLast  = win;
            mSel   = win;
            mValid = 1'b1;
        end else if (mValid && rdy) begin
            mValid = 1'b0;
        end
        if ((|r) && !found && mBusy < 65535) begin
            mBusy++;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] rr;
        logic        rd;
        rst       = 1'b1;
        req       = '0;
        out_ready = 1'b0;
        @(negedge clk);

        $display("[TB] reset with all requests pending");
        resetDut(2, 16'hFFFF);

        $display("[TB] first winner and latency");
        applyStimulus(16'h0011, 1'b1);
        applyStimulus(16'h0011, 1'b1);
        applyStimulus(16'h0000, 1'b1);
        applyStimulus(16'h0000, 1'b1);

        $display("[TB] full rotation");
        resetDut(1, 16'h0000);
        for (int i = 0; i < 18; i++) applyStimulus(16'hFFFF, 1'b1);
        applyStimulus(16'h0000, 1'b1);

        $display("[TB] wrap past 15");
        resetDut(1, 16'h0000);
        applyStimulus(16'h4000, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(16'h4003, 1'b1);
        applyStimulus(16'h0000, 1'b1);
        applyStimulus(16'h0000, 1'b1);

        $display("[TB] backpressure");
        resetDut(1, 16'h0000);
        applyStimulus(16'h0008, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(16'h0100, 1'b0);
        applyStimulus(16'h0100, 1'b1);
        applyStimulus(16'h0000, 1'b1);
        applyStimulus(16'h0000, 1'b1);

        $display("[TB] reset mid-transfer");
        applyStimulus(16'hFFFF, 1'b0);
        applyStimulus(16'h00F0, 1'b0);
        resetDut(1, 16'h00F0);
        applyStimulus(16'hFFFF, 1'b1);
        applyStimulus(16'h0000, 1'b1);

        $display("[TB] random traffic");
        for (int i = 0; i < 300; i++) begin
            rr = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom);
            if ($urandom_range(0, 3) == 0) rr = 16'h0001 << $urandom_range(0, 15);
            rd = ($urandom_range(0, 3) != 0);
            applyStimulus(rr, rd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
